// File: rtl/hack_mem_pkg.sv
// Shared definitions for the RAM DMA engine: default geometry and the FSM state encoding.
package hack_mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable, incrementing address pointer that wraps modulo 2^W; clear beats load beats increment.
module dma_addr_ctr #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next pointer value; the plain add wraps 511+1 to 0 for free.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/ram_dma.sv
// Single-port RAM DMA engine: ascending word copy (read/write pairs) or one-word-per-cycle fill.
module ram_dma
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    dma_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic              mem_load_q, mem_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ptr_clr, ptr_load, src_inc, dst_inc;
    logic [ADDR_W-1:0] src_ptr, src_next, dst_ptr, dst_next;

    dma_addr_ctr #(.W(ADDR_W)) u_src_ctr (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (ptr_clr),
        .load     (ptr_load),
        .load_val (src),
        .inc      (src_inc),
        .cnt      (src_ptr),
        .cnt_next (src_next)
    );

    dma_addr_ctr #(.W(ADDR_W)) u_dst_ctr (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (ptr_clr),
        .load     (ptr_load),
        .load_val (dst),
        .inc      (dst_inc),
        .cnt      (dst_ptr),
        .cnt_next (dst_next)
    );

    // Next-state, operand latching and pointer control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        fill_val_d = fill_val_q;
        ptr_clr    = 1'b0;
        ptr_load   = 1'b0;
        src_inc    = 1'b0;
        dst_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_load   = 1'b1;
                    cnt_d      = len;
                    fill_val_d = fill_value;
                    if (len == LEN_ZERO) begin
                        state_d = ST_DONE;
                    end else if (fill) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                data_d  = mem_out;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                src_inc = 1'b1;
                dst_inc = 1'b1;
                cnt_d   = cnt_q - LEN_ONE;
                state_d = (cnt_q == LEN_ONE) ? ST_DONE : ST_READ;
            end
            ST_FILL: begin
                dst_inc = 1'b1;
                cnt_d   = cnt_q - LEN_ONE;
                state_d = (cnt_q == LEN_ONE) ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                ptr_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs are registered, so they are derived from the state being entered.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        mem_load_d = 1'b0;
        case (state_d)
            ST_READ: begin
                mem_addr_d = src_next;
            end
            ST_WRITE: begin
                mem_addr_d = dst_next;
                mem_in_d   = data_d;
                mem_load_d = 1'b1;
            end
            ST_FILL: begin
                mem_addr_d = dst_next;
                mem_in_d   = fill_val_d;
                mem_load_d = 1'b1;
            end
            default: begin
                mem_load_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= LEN_ZERO;
            data_q     <= {DATA_W{1'b0}};
            fill_val_q <= {DATA_W{1'b0}};
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_in_q   <= {DATA_W{1'b0}};
            mem_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            fill_val_q <= fill_val_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            mem_load_q <= mem_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_in   = mem_in_q;
    assign mem_load = mem_load_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: 512-word RAM model plus an array reference model applying transfers word by word.
module tb_ram_dma;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int WORDS = 512;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          fill;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill_value;
    logic [DW-1:0] mem_out;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_load;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram   [WORDS];
    logic [DW-1:0] model [WORDS];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_load) ram[mem_addr] <= mem_in;
    end
    assign mem_out = ram[mem_addr];

    ram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .fill       (fill),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_value (fill_value),
        .mem_out    (mem_out),
        .mem_addr   (mem_addr),
        .mem_in     (mem_in),
        .mem_load   (mem_load),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference: words move one at a time in ascending order, so overlap propagation falls out.
    task automatic model_xfer(input logic f, input int s, input int d, input int n,
                              input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) begin
            model[(d + i) % WORDS] = f ? v : model[(s + i) % WORDS];
        end
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (ram[i] !== model[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Runs one transfer; poke re-requests with other operands while busy.
    task automatic run_xfer(input string tag, input logic f, input int s, input int d,
                            input int n, input logic [DW-1:0] v, input bit poke);
        int loads;
        int done_at;
        fill       = f;
        src        = s[AW-1:0];
        dst        = d[AW-1:0];
        len        = n[AW:0];
        fill_value = v;
        start      = 1'b1;
        tick;
        start   = 1'b0;
        loads   = 0;
        done_at = -1;
        for (int k = 1; k <= 2 * WORDS + 8; k++) begin
            if (poke && k == 3) begin
                start      = 1'b1;
                src        = src + 9'd37;
                dst        = dst + 9'd91;
                len        = len + 10'd5;
                fill       = ~fill;
                fill_value = ~fill_value;
            end else begin
                start = 1'b0;
            end
            if (mem_load) loads++;
            if (done) begin
                done_at = k;
                break;
            end
            tick;
        end
        start = 1'b0;
        model_xfer(f, s, d, n, v);
        check({tag, "_done_latency"}, done_at, (f ? 1 : 2) * n + 1);
        check({tag, "_writes"}, loads, n);
        tick;
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        tick;
        check({tag, "_no_restart"}, {31'd0, busy}, 32'd0);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        logic [DW-1:0] saved;
        logic [DW-1:0] v;
        int            rs;
        int            rd;
        int            rn;
        logic          rf;

        reset_n    = 1'b0;
        start      = 1'b0;
        fill       = 1'b0;
        src        = 9'd0;
        dst        = 9'd0;
        len        = 10'd0;
        fill_value = 16'h0000;
        for (int i = 0; i < WORDS; i++) begin
            v        = DW'($urandom);
            ram[i]   = v;
            model[i] = v;
        end
        tick;
        tick;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_load", {31'd0, mem_load}, 32'd0);
        check("rst_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_in", {16'd0, mem_in}, 32'd0);
        reset_n = 1'b1;
        tick;

        // Basic copy of four known words.
        ram[10] = 16'hA0A0; ram[11] = 16'hB1B1; ram[12] = 16'hC2C2; ram[13] = 16'hD3D3;
        model[10] = 16'hA0A0; model[11] = 16'hB1B1; model[12] = 16'hC2C2; model[13] = 16'hD3D3;
        run_xfer("copy4", 1'b0, 10, 100, 4, 16'h0000, 1'b0);
        check("copy4_dst0", {16'd0, ram[100]}, {16'd0, 16'hA0A0});
        check("copy4_dst3", {16'd0, ram[103]}, {16'd0, 16'hD3D3});
        check("copy4_src3", {16'd0, ram[13]}, {16'd0, 16'hD3D3});

        // Fill across the top-of-memory wrap.
        saved = ram[2];
        run_xfer("fillwrap", 1'b1, 0, 510, 4, 16'hBEEF, 1'b0);
        check("fill_510", {16'd0, ram[510]}, {16'd0, 16'hBEEF});
        check("fill_1", {16'd0, ram[1]}, {16'd0, 16'hBEEF});
        check("fill_2_untouched", {16'd0, ram[2]}, {16'd0, saved});

        run_xfer("len0", 1'b0, 5, 6, 0, 16'h0000, 1'b0);

        // Overlapping ascending copy propagates the first word.
        ram[0]   = 16'd7;
        model[0] = 16'd7;
        run_xfer("overlap", 1'b0, 0, 1, 3, 16'h0000, 1'b0);
        check("overlap_3", {16'd0, ram[3]}, 32'd7);

        run_xfer("poke", 1'b0, 20, 300, 6, 16'h0000, 1'b1);

        // Reset while the third word of an 8-word copy is being read.
        fill  = 1'b0;
        src   = 9'd200;
        dst   = 9'd300;
        len   = 10'd8;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_load", {31'd0, mem_load}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_addr", {23'd0, mem_addr}, 32'd0);
        model_xfer(1'b0, 200, 300, 2, 16'h0000);
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        tick;
        check("arst_no_resume", {31'd0, busy}, 32'd0);
        check_mem("arst_mem");
        run_xfer("after_rst", 1'b0, 200, 300, 8, 16'h0000, 1'b0);

        for (int it = 0; it < 8; it++) begin
            rf = 1'($urandom_range(0, 1));
            rs = int'($urandom_range(0, WORDS - 1));
            rd = int'($urandom_range(0, WORDS - 1));
            rn = int'($urandom_range(0, 60));
            v  = DW'($urandom);
            run_xfer("rand", rf, rs, rd, rn, v, 1'b0);
        end

        run_xfer("fill512", 1'b1, 0, 77, 512, 16'h5A3C, 1'b0);
        for (int i = 0; i < WORDS; i++) begin
            v        = DW'($urandom);
            ram[i]   = v;
            model[i] = v;
        end
        run_xfer("copy512", 1'b0, 0, 256, 512, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter ADDR_W, default 9, shall set the word-address width (512-word space).
REQ-002 Parameter DATA_W, default 16, shall set the data word width.
REQ-003 clock  input  1  shall be the single clock; all state updates on posedge.
REQ-004 reset_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 start  input  1  shall request a transfer when sampled high in IDLE.
REQ-006 fill  input  1  shall select fill mode (1) or copy mode (0); sampled with start.
REQ-007 src  input  ADDR_W  shall give the copy source base address; sampled with start.
REQ-008 dst  input  ADDR_W  shall give the destination base address; sampled with start.
REQ-009 len  input  ADDR_W+1  shall give the word count, 0..512; sampled with start.
REQ-010 fill_value  input  DATA_W  shall give the fill word; sampled with start.
REQ-011 mem_out  input  DATA_W  shall carry the memory's combinational read data for mem_addr.
REQ-012 mem_addr  output  ADDR_W  shall drive the memory address.
REQ-013 mem_in  output  DATA_W  shall drive the memory write data.
REQ-014 mem_load  output  1  shall drive the memory write enable; the write commits at the next posedge.
REQ-015 busy  output  1  shall be high in every state except IDLE.
REQ-016 done  output  1  shall pulse high for exactly one cycle when a transfer completes.

Function
REQ-017 The FSM shall have states IDLE, READ, WRITE, FILL and DONE.
REQ-018 IDLE shall go to DONE on start with len=0, to FILL on start with fill=1, and to READ otherwise; the block shall not write when len=0.
REQ-019 In READ, the block shall drive mem_addr=src_ptr with mem_load=0, capture mem_out into a data register at the posedge, and go to WRITE.
REQ-020 In WRITE, the block shall drive mem_addr=dst_ptr, mem_in=data register and mem_load=1; it shall then increment both pointers, decrement the remaining count, and go to READ, or to DONE when the count reaches 0.
REQ-021 Copy mode shall take exactly 2 cycles per word; fill mode shall take exactly 1 cycle per word.
REQ-022 In FILL, the block shall drive mem_addr=dst_ptr, mem_in=fill_value (latched) and mem_load=1 every cycle until the count reaches 0, then go to DONE.
REQ-023 DONE shall assert done for one cycle and return to IDLE; the block shall accept a new start no earlier than the following cycle.
REQ-024 Pointers shall wrap modulo 2^ADDR_W (511+1=0).
REQ-025 The copy shall always ascend in address; with overlapping regions where dst>src, already-written words shall be re-read (defined, intentional propagation).
REQ-026 start shall be ignored while busy=1; the latched operands shall not change mid-transfer.
REQ-027 mem_load shall be 0 in IDLE, READ and DONE; when mem_load=0, mem_addr and mem_in shall hold their last driven value.
REQ-028 len>512 shall be impossible by width; len=512 shall touch every address exactly once.

Reset
REQ-029 reset_n low shall immediately force IDLE, mem_load=0, busy=0, done=0, mem_addr=0, mem_in=0 and clear the pointers, count and data register, including mid-transfer.
REQ-030 A transfer interrupted by reset shall not resume; words already written shall remain in memory.

Structure
REQ-031 Shared package hack_mem_pkg shall hold the ADDR_W/DATA_W defaults and the FSM state encoding (3-bit: IDLE=0, READ=1, WRITE=2, FILL=3, DONE=4).
REQ-032 A single sub-module, dma_addr_ctr (loadable, incrementing, wrapping ADDR_W counter with a clear), shall be instantiated twice, once for src_ptr and once for dst_ptr.
REQ-033 The bench shall connect the block to the existing 512-word RAM model (mem_addr→address, mem_in→in, mem_load→load, out→mem_out).

Verification
REQ-034 Preload RAM[10..13]=A,B,C,D; start copy src=10 dst=100 len=4 -> RAM[100..103]=A,B,C,D, done pulses 8 cycles after start, and RAM[10..13] is unchanged.
REQ-035 Fill dst=510 len=4 value=16'hBEEF -> RAM[510],[511],[0],[1]=BEEF, done 4 cycles after start, and RAM[2] is untouched.
REQ-036 start with len=0 -> done the next cycle, mem_load never high.
REQ-037 Overlap: RAM[0]=7, copy src=0 dst=1 len=3 -> RAM[1..3]=7.
REQ-038 Assert reset_n low after 2 words of an 8-word copy -> mem_load=0 and busy=0 asynchronously; exactly 2 words are written; a new start afterwards works normally.
REQ-039 Pulse start again while busy with different src/dst -> original transfer completes unaltered and the second request is dropped.
